// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, data-memory wait freezes,
// branch flushes (including flushes deferred across a stall), statistics
// counters and a sticky memory-wait timeout flag.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  output logic        pc_write_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        freeze_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o,
  output logic        err_timeout_o
);

  typedef enum logic [0:0] {StRun, StMwait} state_e;

  state_e      state_q, state_d;
  logic        pending_flush_q, pending_flush_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        err_timeout_q, err_timeout_d;

  logic load_use;
  logic mem_wait;
  logic flush_req;

  // Hazard detection; r0 is hardwired zero so it never creates a dependency.
  always_comb begin
    load_use  = idex_memread_i && (idex_rt_i != 5'd0) &&
                ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    mem_wait  = (state_q == StMwait) ? !dmem_ready_i : (dmem_req_i && !dmem_ready_i);
    flush_req = branch_taken_i || pending_flush_q;
  end

  // Control outputs: one action per cycle, mem_wait > load_use > flush.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    freeze_o      = 1'b0;
    if (!rst_i) begin
      if (mem_wait) begin
        pc_write_o   = 1'b0;
        ifid_stall_o = 1'b1;
        freeze_o     = 1'b1;
      end else if (load_use) begin
        pc_write_o    = 1'b0;
        ifid_stall_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end else if (flush_req) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

  // Next-state: FSM, deferred flush, wait counter, statistics, timeout.
  always_comb begin
    state_d         = state_q;
    pending_flush_d = pending_flush_q;
    wait_cnt_d      = wait_cnt_q;
    stall_cnt_d     = stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    err_timeout_d   = err_timeout_q;

    if (mem_wait || load_use) begin
      if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      // A branch resolved while stalled must not be lost; replay it later.
      if (branch_taken_i) pending_flush_d = 1'b1;
    end else if (flush_req) begin
      if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
      pending_flush_d = 1'b0;
    end

    case (state_q)
      StRun: begin
        if (dmem_req_i && !dmem_ready_i) begin
          state_d    = StMwait;
          wait_cnt_d = 8'd0;
        end
      end
      StMwait: begin
        if (dmem_ready_i) begin
          state_d = StRun;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = StRun;
    endcase

    // Timeout only flags; the FSM keeps waiting for ready.
    if ((state_d == StMwait) && (32'(wait_cnt_d) == TIMEOUT)) err_timeout_d = 1'b1;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StRun;
      pending_flush_q <= 1'b0;
      wait_cnt_q      <= 8'd0;
      stall_cnt_q     <= 16'd0;
      flush_cnt_q     <= 16'd0;
      err_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_flush_q <= pending_flush_d;
      wait_cnt_q      <= wait_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      err_timeout_q   <= err_timeout_d;
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign err_timeout_o = err_timeout_q;

endmodule
